// File: rtl/serv_rf_ram_bridge.sv
// serv_rf_ram_bridge: bit-serial two-read/two-write register file ports mapped onto a W-bit 1R1W synchronous RAM
// i_rreq/i_rreg0/i_rreg1 start a read; o_ready precedes LSB-first o_rdata0/o_rdata1
// i_wreq/i_wreg*/i_wen* start a write; i_wdata0/i_wdata1 arrive LSB first
// o_raddr/o_ren/i_rdata and o_waddr/o_wdata/o_wen drive the RAM macro
module serv_rf_ram_bridge #(
  parameter int width = 8,
  parameter int csr_regs = 4,
  localparam int RW = csr_regs == 0 ? 5 : 6,
  localparam int WPR = 32 / width,
  localparam int AW = $clog2((32 + csr_regs) * WPR)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rreq,
  input  logic [RW-1:0]    i_rreg0,
  input  logic [RW-1:0]    i_rreg1,
  output logic             o_ready,
  output logic             o_rdata0,
  output logic             o_rdata1,
  input  logic             i_wreq,
  input  logic [RW-1:0]    i_wreg0,
  input  logic [RW-1:0]    i_wreg1,
  input  logic             i_wen0,
  input  logic             i_wen1,
  input  logic             i_wdata0,
  input  logic             i_wdata1,
  output logic [AW-1:0]    o_waddr,
  output logic [width-1:0] o_wdata,
  output logic             o_wen,
  output logic [AW-1:0]    o_raddr,
  output logic             o_ren,
  input  logic [width-1:0] i_rdata
);
  localparam int LB = $clog2(width);
  localparam int LW = $clog2(WPR);
  typedef enum logic {IDLE, BUSY} st_t;
  st_t rs, ws;
  logic [5:0] rc, wc, rn, rb0, rb1;
  logic [RW-1:0] rr0, rr1, rg0, wr0, wr1;
  logic ract, rgo, rp0, rp1, r0, r1, d0, d1;
  logic [width-1:0] stage, sr0, sr1, c0, c1, n0, n1, s1;
  logic wact, wsamp, wdone, we0, we1, p1;
  logic [AW-1:0] a1;
  function automatic logic [AW-1:0] addr(input logic [RW-1:0] r, input logic [5:0] b);
    return (AW'(r) << LW) | AW'(b >> LB);
  endfunction
  // rn is the cycle number (relative to i_rreq) about to start; strobes are registered one cycle ahead
  assign ract = rs == BUSY;
  assign rgo = ract | i_rreq;
  assign rn = ract ? rc + 6'd1 : 6'd1;
  assign rb0 = rn - 6'd1;
  assign rb1 = rn - 6'd2;
  assign rp0 = rgo && rb0[LB-1:0] == '0 && rb0 < 6'd32;
  assign rp1 = ract && rn >= 6'd2 && rb1[LB-1:0] == '0 && rb1 < 6'd32;
  assign rg0 = ract ? rr0 : i_rreg0;
  assign o_ren = r0 | r1;
  assign o_rdata0 = sr0[0] & (|rr0);
  assign o_rdata1 = sr1[0] & (|rr1);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rs <= IDLE;
      rc <= '0;
      rr0 <= '0;
      rr1 <= '0;
      r0 <= 1'b0;
      r1 <= 1'b0;
      d0 <= 1'b0;
      d1 <= 1'b0;
      o_raddr <= '0;
      o_ready <= 1'b0;
      stage <= '0;
      sr0 <= '0;
      sr1 <= '0;
    end else begin
      if (!ract && i_rreq) begin
        rs <= BUSY;
        rc <= 6'd1;
        rr0 <= i_rreg0;
        rr1 <= i_rreg1;
      end else if (ract) begin
        rc <= rc + 6'd1;
        if (rc == 6'd35) rs <= IDLE;
      end
      r0 <= rp0;
      r1 <= rp1;
      if (rp0 | rp1) o_raddr <= rp0 ? addr(rg0, rb0) : addr(rr1, rb1);
      o_ready <= ract && rc == 6'd2;
      d0 <= r0;
      d1 <= r1;
      // port 0 word arrives a cycle before port 1, so it waits in stage to load both shifters together
      if (d0) stage <= i_rdata;
      sr0 <= d1 ? stage : sr0 >> 1;
      sr1 <= d1 ? i_rdata : sr1 >> 1;
    end
  end
  assign wact = ws == BUSY;
  assign wsamp = wact && wc <= 6'd32;
  assign wdone = wsamp && wc[LB-1:0] == '0;
  assign n0 = {i_wdata0, c0[width-1:1]};
  assign n1 = {i_wdata1, c1[width-1:1]};
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ws <= IDLE;
      wc <= '0;
      wr0 <= '0;
      wr1 <= '0;
      we0 <= 1'b0;
      we1 <= 1'b0;
      c0 <= '0;
      c1 <= '0;
      s1 <= '0;
      a1 <= '0;
      p1 <= 1'b0;
      o_wen <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
    end else begin
      if (!wact && i_wreq) begin
        ws <= BUSY;
        wc <= 6'd1;
        wr0 <= i_wreg0;
        wr1 <= i_wreg1;
        we0 <= i_wen0;
        we1 <= i_wen1;
      end else if (wact) begin
        wc <= wc + 6'd1;
        if (wc == 6'd34) ws <= IDLE;
      end
      if (wsamp) begin
        c0 <= n0;
        c1 <= n1;
      end
      // port 1 word completes with port 0 and is written the following cycle
      p1 <= wdone;
      if (wdone) begin
        s1 <= n1;
        a1 <= addr(wr1, wc - 6'd1);
      end
      o_wen <= wdone ? we0 & (|wr0) : p1 & we1;
      if (wdone) begin
        o_waddr <= addr(wr0, wc - 6'd1);
        o_wdata <= n0;
      end else if (p1) begin
        o_waddr <= a1;
        o_wdata <= s1;
      end
    end
  end
endmodule

// File: tb/tb_serv_rf_ram_bridge.sv
// tb_serv_rf_ram_bridge: scoreboard bench for W=8, W=2 and W=32 bridges sharing one clock and reset
module tb_serv_rf_ram_bridge;
  typedef struct {int c; int a; logic [31:0] d;} ev_t;
  localparam int WS [3] = '{8, 2, 32};
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, total = 0, bad = 0;
  logic rreq[3], wreq[3], we0[3], we1[3], wb0[3], wb1[3];
  logic [5:0] rr0[3], rr1[3], wr0[3], wr1[3];
  logic rdy[3], q0[3], q1[3], wen[3], ren[3];
  logic [9:0] wa[3], ra[3];
  logic [31:0] wd[3], rdq[3];
  logic [31:0] mem[3][1024];
  logic [7:0] wa_a, ra_a, wd_a;
  logic [9:0] wa_b, ra_b;
  logic [1:0] wd_b;
  logic [5:0] wa_c, ra_c;
  logic [31:0] wd_c;
  ev_t wq[3][$], eq[3][$], yq[3][$], bq[3][$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign wa[0] = 10'(wa_a);
  assign ra[0] = 10'(ra_a);
  assign wd[0] = 32'(wd_a);
  assign wa[1] = wa_b;
  assign ra[1] = ra_b;
  assign wd[1] = 32'(wd_b);
  assign wa[2] = 10'(wa_c);
  assign ra[2] = 10'(ra_c);
  assign wd[2] = wd_c;
  serv_rf_ram_bridge #(.width(8), .csr_regs(4)) u_a (
    .i_clk(clk), .i_rst(rst), .i_rreq(rreq[0]), .i_rreg0(rr0[0]), .i_rreg1(rr1[0]),
    .o_ready(rdy[0]), .o_rdata0(q0[0]), .o_rdata1(q1[0]), .i_wreq(wreq[0]),
    .i_wreg0(wr0[0]), .i_wreg1(wr1[0]), .i_wen0(we0[0]), .i_wen1(we1[0]),
    .i_wdata0(wb0[0]), .i_wdata1(wb1[0]), .o_waddr(wa_a), .o_wdata(wd_a), .o_wen(wen[0]),
    .o_raddr(ra_a), .o_ren(ren[0]), .i_rdata(rdq[0][7:0]));
  serv_rf_ram_bridge #(.width(2), .csr_regs(4)) u_b (
    .i_clk(clk), .i_rst(rst), .i_rreq(rreq[1]), .i_rreg0(rr0[1]), .i_rreg1(rr1[1]),
    .o_ready(rdy[1]), .o_rdata0(q0[1]), .o_rdata1(q1[1]), .i_wreq(wreq[1]),
    .i_wreg0(wr0[1]), .i_wreg1(wr1[1]), .i_wen0(we0[1]), .i_wen1(we1[1]),
    .i_wdata0(wb0[1]), .i_wdata1(wb1[1]), .o_waddr(wa_b), .o_wdata(wd_b), .o_wen(wen[1]),
    .o_raddr(ra_b), .o_ren(ren[1]), .i_rdata(rdq[1][1:0]));
  serv_rf_ram_bridge #(.width(32), .csr_regs(4)) u_c (
    .i_clk(clk), .i_rst(rst), .i_rreq(rreq[2]), .i_rreg0(rr0[2]), .i_rreg1(rr1[2]),
    .o_ready(rdy[2]), .o_rdata0(q0[2]), .o_rdata1(q1[2]), .i_wreq(wreq[2]),
    .i_wreg0(wr0[2]), .i_wreg1(wr1[2]), .i_wen0(we0[2]), .i_wen1(we1[2]),
    .i_wdata0(wb0[2]), .i_wdata1(wb1[2]), .o_waddr(wa_c), .o_wdata(wd_c), .o_wen(wen[2]),
    .o_raddr(ra_c), .o_ren(ren[2]), .i_rdata(rdq[2]));
  always @(posedge clk)
    for (int i = 0; i < 3; i++) begin
      if (wen[i]) mem[i][wa[i]] <= wd[i];
      if (ren[i]) rdq[i] <= mem[i][ra[i]];
    end
  task automatic chk(input string t, input logic [63:0] o, input logic [63:0] x);
    total++;
    assert (o === x) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, x);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    ev_t e;
    for (int i = 0; i < 3; i++) begin
      if (wen[i]) begin
        if (wq[i].size() == 0) chk("wen_extra", 64'(cyc), 64'(-1));
        else begin
          e = wq[i].pop_front();
          chk("wen_cyc", 64'(cyc), 64'(e.c));
          chk("waddr", 64'(wa[i]), 64'(e.a));
          chk("wdata", 64'(wd[i]), 64'(e.d));
        end
      end
      if (ren[i]) begin
        if (eq[i].size() == 0) chk("ren_extra", 64'(cyc), 64'(-1));
        else begin
          e = eq[i].pop_front();
          chk("ren_cyc", 64'(cyc), 64'(e.c));
          chk("raddr", 64'(ra[i]), 64'(e.a));
        end
      end
      if (rdy[i]) begin
        if (yq[i].size() == 0) chk("ready_extra", 64'(cyc), 64'(-1));
        else begin
          e = yq[i].pop_front();
          chk("ready_cyc", 64'(cyc), 64'(e.c));
        end
      end
      if (bq[i].size() != 0 && bq[i][0].c == cyc) begin
        e = bq[i].pop_front();
        chk("rdata0", 64'(q0[i]), 64'(e.d[0]));
        chk("rdata1", 64'(q1[i]), 64'(e.d[1]));
      end
    end
  end
  task automatic wr(input int i, input logic [5:0] r0, input logic [5:0] r1, input logic e0,
                    input logic e1, input logic [31:0] v0, input logic [31:0] v1, input int lim);
    int w, n, c0, t;
    logic [63:0] m;
    w = WS[i];
    n = 32 / w;
    c0 = cyc;
    m = (64'd1 << w) - 64'd1;
    wreq[i] = 1'b1;
    wr0[i] = r0;
    wr1[i] = r1;
    we0[i] = e0;
    we1[i] = e1;
    for (int k = 0; k < n; k++) begin
      t = w * (k + 1) + 1;
      if (e0 && r0 != 0 && t <= lim)
        wq[i].push_back('{c0 + t, int'(r0) * n + k, 32'((64'(v0) >> (k * w)) & m)});
      if (e1 && t + 1 <= lim)
        wq[i].push_back('{c0 + t + 1, int'(r1) * n + k, 32'((64'(v1) >> (k * w)) & m)});
    end
    tick;
    wreq[i] = 1'b0;
    for (int b = 0; b < 32 && b + 1 <= lim; b++) begin
      wb0[i] = v0[b];
      wb1[i] = v1[b];
      tick;
    end
    wb0[i] = 1'b0;
    wb1[i] = 1'b0;
    while (cyc < c0 + (lim < 34 ? lim + 1 : 35)) tick;
  endtask
  task automatic rd(input int i, input logic [5:0] r0, input logic [5:0] r1,
                    input logic [31:0] v0, input logic [31:0] v1, input int lim);
    int w, n, c0, t;
    w = WS[i];
    n = 32 / w;
    c0 = cyc;
    rreq[i] = 1'b1;
    rr0[i] = r0;
    rr1[i] = r1;
    if (lim >= 3) yq[i].push_back('{c0 + 3, 0, 32'd0});
    for (int k = 0; k < n; k++) begin
      t = 1 + k * w;
      if (t <= lim) eq[i].push_back('{c0 + t, int'(r0) * n + k, 32'd0});
      if (t + 1 <= lim) eq[i].push_back('{c0 + t + 1, int'(r1) * n + k, 32'd0});
    end
    for (int b = 0; b < 32 && b + 4 <= lim; b++)
      bq[i].push_back('{c0 + 4 + b, 0, {30'd0, r1 != 0 && v1[b], r0 != 0 && v0[b]}});
    tick;
    rreq[i] = 1'b0;
    while (cyc < c0 + (lim < 35 ? lim + 1 : 36)) tick;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal;
  end
  initial begin
    int c0;
    for (int i = 0; i < 3; i++) begin
      rreq[i] = 1'b0; wreq[i] = 1'b0; we0[i] = 1'b0; we1[i] = 1'b0; wb0[i] = 1'b0; wb1[i] = 1'b0;
      rr0[i] = '0; rr1[i] = '0; wr0[i] = '0; wr1[i] = '0;
    end
    repeat (3) tick;
    for (int i = 0; i < 3; i++)
      chk("reset_outputs", 64'({wen[i], ren[i], rdy[i], q0[i], q1[i], wa[i], ra[i], wd[i]}), 64'd0);
    rst = 1'b0;
    tick;
    wr(0, 6'd5, 6'd6, 1'b1, 1'b1, 32'hA5A5_1234, 32'h0F0F_F0F0, 99);
    rd(0, 6'd5, 6'd6, 32'hA5A5_1234, 32'h0F0F_F0F0, 99);
    wr(0, 6'd0, 6'd7, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h600D_F00D, 99);
    rd(0, 6'd0, 6'd7, 32'hFFFF_FFFF, 32'h600D_F00D, 99);
    rd(0, 6'd7, 6'd0, 32'h600D_F00D, 32'hFFFF_FFFF, 99);
    wr(1, 6'd1, 6'd34, 1'b1, 1'b1, 32'h1357_9BDF, 32'hCAFE_F00D, 99);
    fork
      rd(1, 6'd1, 6'd34, 32'h1357_9BDF, 32'hCAFE_F00D, 99);
      wr(1, 6'd2, 6'd33, 1'b1, 1'b1, 32'h2468_ACE0, 32'hDEAD_BEEF, 99);
    join
    rd(1, 6'd2, 6'd33, 32'h2468_ACE0, 32'hDEAD_BEEF, 99);
    c0 = cyc;
    fork
      rd(0, 6'd7, 6'd8, 32'h600D_F00D, 32'h0, 10);
      wr(0, 6'd9, 6'd10, 1'b1, 1'b1, 32'h1111_2222, 32'h3333_4444, 10);
      begin
        repeat (10) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
      end
    join
    chk("abort_cycle", 64'(cyc), 64'(c0 + 11));
    chk("abort_zero_c11", 64'({wen[0], ren[0], rdy[0], q0[0], q1[0], wa[0], ra[0], wd[0]}), 64'd0);
    tick;
    chk("abort_zero_c12", 64'({wen[0], ren[0], rdy[0], q0[0], q1[0], wa[0], ra[0], wd[0]}), 64'd0);
    rd(0, 6'd5, 6'd6, 32'hA5A5_1234, 32'h0F0F_F0F0, 99);
    wr(2, 6'd3, 6'd4, 1'b1, 1'b0, 32'h89AB_CDEF, 32'h5555_5555, 99);
    fork
      rd(2, 6'd3, 6'd3, 32'h89AB_CDEF, 32'h89AB_CDEF, 99);
      begin
        repeat (5) tick;
        rreq[2] = 1'b1;
        rr0[2] = 6'd4;
        rr1[2] = 6'd4;
        tick;
        rreq[2] = 1'b0;
      end
    join
    repeat (4) tick;
    for (int i = 0; i < 3; i++)
      chk("scoreboard_empty", 64'(wq[i].size() + eq[i].size() + yq[i].size() + bq[i].size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
